// File: rtl/dec_byte_loader.sv
// -----------------------------------------------------------------------------
// dec_byte_loader
//
// Byte-stream wrapper around the iterative AES decipher core. It collects 16
// ciphertext bytes into a 128-bit block and drives the core's `in` and
// `decReset`. It waits out the core's fixed latency, captures the 128-bit
// result and streams the plaintext back out MSB-first. Both sides use
// valid/ready handshakes and move at most one byte per cycle.
//
// Parameters
//   Nk         key length in 32-bit words (4/6/8); must match the core.
//
// Ports
//   clk        clock, rising edge
//   rstN       asynchronous active-low reset
//   in_valid   ciphertext byte valid
//   in_ready   loader accepts a ciphertext byte this cycle
//   in_byte    ciphertext byte; first byte of a block lands in dec_in[127:120]
//   dec_reset  to core decReset; high holds the core idle
//   dec_in     to core `in`
//   dec_out    from core `out`
//   out_valid  plaintext byte valid
//   out_ready  downstream accepts a plaintext byte
//   out_byte   plaintext byte, dec_out[127:120] first
//   busy       high while running the core or draining plaintext
//
// Build option
//   DEC_LOADER_OVERLAP_EN  when defined, the next block may be loaded while
//                          the current plaintext drains, and RUN can follow
//                          DRAIN directly.
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_LOAD  | collecting ciphertext bytes, core held in reset
// ST_RUN   | core running; counting edges until its output is stable
// ST_DRAIN | shifting plaintext bytes out (optionally loading next block)

module dec_byte_loader #(
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  output logic         dec_reset,
  output logic [127:0] dec_in,
  input  logic [127:0] dec_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         busy
);

  localparam int Nr = Nk + 6;
  // Core registers its result on edge Nr+1 after decReset falls; capturing
  // one edge later leaves a cycle of margin.
  localparam logic [4:0] RUN_LAST = 5'(Nr + 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     in_cnt_q, in_cnt_d;
  logic [4:0]     run_cnt_q, run_cnt_d;
  logic [3:0]     out_cnt_q, out_cnt_d;
  logic [127:0]   shift_q, shift_d;
  logic [127:0]   dec_in_q, dec_in_d;
  logic           dec_reset_q, dec_reset_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           in_acc;
  logic           out_acc;
`ifdef DEC_LOADER_OVERLAP_EN
  // in_cnt wraps at 16, so a full next block is remembered separately.
  logic           held_full_q, held_full_d;
`endif

  // Replace byte `idx` (0 = most significant) of a 128-bit block.
  function automatic logic [127:0] put_byte(input logic [127:0] blk,
                                            input logic [3:0]   idx,
                                            input logic [7:0]   b);
    logic [127:0] r;
    r = blk;
    for (int i = 0; i < 16; i++) begin
      if (idx == 4'(i)) r[127-8*i -: 8] = b;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    run_cnt_d   = run_cnt_q;
    out_cnt_d   = out_cnt_q;
    shift_d     = shift_q;
    dec_in_d    = dec_in_q;
    dec_reset_d = dec_reset_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef DEC_LOADER_OVERLAP_EN
    held_full_d = held_full_q;
`endif
    in_acc      = in_valid && in_ready_q;
    out_acc     = out_valid_q && out_ready;

    unique case (state_q)
      ST_LOAD: begin
        if (in_acc) begin
          dec_in_d = put_byte(dec_in_q, in_cnt_q, in_byte);
          in_cnt_d = in_cnt_q + 4'd1;
          if (in_cnt_q == 4'd15) begin
            state_d     = ST_RUN;
            dec_reset_d = 1'b0;
            in_ready_d  = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          shift_d     = dec_out;
          state_d     = ST_DRAIN;
          dec_reset_d = 1'b1;
          run_cnt_d   = 5'd0;
          out_valid_d = 1'b1;
`ifdef DEC_LOADER_OVERLAP_EN
          in_ready_d  = 1'b1;
`endif
        end else begin
          run_cnt_d = run_cnt_q + 5'd1;
        end
      end

      ST_DRAIN: begin
`ifdef DEC_LOADER_OVERLAP_EN
        // Core is held in reset here, so overwriting dec_in is harmless.
        if (in_acc) begin
          dec_in_d = put_byte(dec_in_q, in_cnt_q, in_byte);
          in_cnt_d = in_cnt_q + 4'd1;
          if (in_cnt_q == 4'd15) begin
            held_full_d = 1'b1;
            in_ready_d  = 1'b0;
          end
        end
`endif
        if (out_acc) begin
          shift_d   = {shift_q[119:0], 8'h00};
          out_cnt_d = out_cnt_q + 4'd1;
          if (out_cnt_q == 4'd15) begin
            out_valid_d = 1'b0;
            state_d     = ST_LOAD;
            in_ready_d  = 1'b1;
`ifdef DEC_LOADER_OVERLAP_EN
            // A 16th byte taken on this same edge also completes the block.
            if (held_full_q || (in_acc && in_cnt_q == 4'd15)) begin
              state_d     = ST_RUN;
              dec_reset_d = 1'b0;
              in_ready_d  = 1'b0;
              held_full_d = 1'b0;
            end
`endif
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase

    busy_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_LOAD;
      in_cnt_q    <= 4'd0;
      run_cnt_q   <= 5'd0;
      out_cnt_q   <= 4'd0;
      shift_q     <= 128'd0;
      dec_in_q    <= 128'd0;
      dec_reset_q <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      run_cnt_q   <= run_cnt_d;
      out_cnt_q   <= out_cnt_d;
      shift_q     <= shift_d;
      dec_in_q    <= dec_in_d;
      dec_reset_q <= dec_reset_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef DEC_LOADER_OVERLAP_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      held_full_q <= 1'b0;
    end else begin
      held_full_q <= held_full_d;
    end
  end
`endif

  assign in_ready  = in_ready_q;
  assign dec_reset = dec_reset_q;
  assign dec_in    = dec_in_q;
  assign out_valid = out_valid_q;
  // The shift register's top byte is the registered plaintext byte.
  assign out_byte  = shift_q[127:120];
  assign busy      = busy_q;

endmodule

// File: tb/tb_dec_byte_loader.sv
module tb_dec_byte_loader;

  localparam int NK  = 4;
  localparam int NR  = NK + 6;
  localparam int LAT = NR + 2;

  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] XMASK   = {16{8'hA5}};

  logic         clk;
  logic         rstN;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         dec_reset;
  logic [127:0] dec_in;
  logic [127:0] dec_out;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_byte;
  logic         busy;

  int tests = 0;
  int fails = 0;

  logic [127:0] ct_a, ct_b, ct_r, pt_a, pt_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dec_byte_loader #(.Nk(NK)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .dec_reset (dec_reset),
    .dec_in    (dec_in),
    .dec_out   (dec_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .busy      (busy)
  );

  // Stand-in decipher: output is junk until edge NR+1 after decReset falls,
  // then holds the plaintext. FIPS ciphertext maps to the FIPS plaintext,
  // anything else to ct ^ A5..A5.
  function automatic logic [127:0] model_pt(input logic [127:0] c);
    if (c == FIPS_CT) return FIPS_PT;
    return c ^ XMASK;
  endfunction

  int core_cnt = 0;
  always @(posedge clk) begin
    if (dec_reset) begin
      core_cnt <= 0;
      dec_out  <= {4{32'hDEADBEEF}};
    end else if (core_cnt < NR + 1) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 == NR + 1) dec_out <= model_pt(dec_in);
      else                        dec_out <= {16{8'(core_cnt + 8'h30)}};
    end
  end

  function automatic logic [7:0] get_byte(input logic [127:0] v, input int j);
    return v[127-8*j -: 8];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [127:0] ct);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_byte  = get_byte(ct, i);
      tick();
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  // Count edges from the block-completing edge until out_valid rises.
  task automatic wait_out(input int start, input string tag);
    int n;
    n = start;
    while (out_valid !== 1'b1 && n < LAT + 20) begin
      tick();
      n++;
    end
    chk(tag, 128'(n), 128'(LAT));
  endtask

  task automatic drain(input logic [127:0] pt, input string tag);
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("%s_byte%0d", tag, j), 128'(out_byte), 128'(get_byte(pt, j)));
`ifndef DEC_LOADER_OVERLAP_EN
      if (j == 3) chk({tag, "_in_ready_drain"}, 128'(in_ready), 128'(1'b0));
`endif
      tick();
    end
    chk({tag, "_valid_low"}, 128'(out_valid), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstN      = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    ct_a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    ct_b = 128'hfedcba98765432100123456789abcdef;
    ct_r = 128'h55aa55aa00ff00ff1234567890abcdef;
    pt_a = ct_a ^ XMASK;
    pt_b = ct_b ^ XMASK;

    // Reset values
    tick();
    tick();
    chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
    chk("rst_dec_reset", 128'(dec_reset), 128'(1'b1));
    chk("rst_dec_in",    dec_in,          128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_out_byte",  128'(out_byte),  128'(8'h00));
    chk("rst_busy",      128'(busy),      128'(1'b0));
    rstN = 1'b1;
    tick();

    // FIPS-197 block at full rate, plus ignored input during RUN
    send_block(FIPS_CT);
    chk("run_in_ready",  128'(in_ready),  128'(1'b0));
    chk("run_dec_reset", 128'(dec_reset), 128'(1'b0));
    chk("run_busy",      128'(busy),      128'(1'b1));
    chk("run_dec_in",    dec_in,          FIPS_CT);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    repeat (5) tick();
    in_valid = 1'b0;
    in_byte  = 8'h00;
    chk("ignored_dec_in",   dec_in,          FIPS_CT);
    chk("ignored_in_ready", 128'(in_ready),  128'(1'b0));
    wait_out(5, "lat_fips");
    chk("drain_busy",      128'(busy),      128'(1'b1));
    chk("drain_dec_reset", 128'(dec_reset), 128'(1'b1));
`ifdef DEC_LOADER_OVERLAP_EN
    chk("drain_in_ready",  128'(in_ready),  128'(1'b1));
`else
    chk("drain_in_ready",  128'(in_ready),  128'(1'b0));
`endif
    drain(FIPS_PT, "fips");
    chk("post_busy",     128'(busy),     128'(1'b0));
    chk("post_in_ready", 128'(in_ready), 128'(1'b1));

    // Input gaps and an output stall at byte 7
    begin
      int i;
      int c;
      i = 0;
      c = 0;
      while (i < 16 && c < 64) begin
        if (c % 3 == 2) begin
          in_valid = 1'b0;
          in_byte  = 8'hCC;
        end else begin
          in_valid = 1'b1;
          in_byte  = get_byte(FIPS_CT, i);
          i++;
        end
        tick();
        c++;
      end
      in_valid = 1'b0;
      in_byte  = 8'h00;
    end
    chk("bp_dec_in", dec_in, FIPS_CT);
    wait_out(0, "lat_bp");
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (j == 7) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk($sformatf("stall_byte%0d", s),  128'(out_byte),  128'(8'h77));
          chk($sformatf("stall_valid%0d", s), 128'(out_valid), 128'(1'b1));
          tick();
        end
        out_ready = 1'b1;
      end
      chk($sformatf("bp_byte%0d", j), 128'(out_byte), 128'(get_byte(FIPS_PT, j)));
      tick();
    end
    chk("bp_valid_low", 128'(out_valid), 128'(1'b0));
    chk("bp_busy",      128'(busy),      128'(1'b0));

    // Reset after 9 input bytes, checked before any clock edge
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_byte  = get_byte(ct_r, i);
      tick();
    end
    in_valid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    chk("mrl_in_ready",  128'(in_ready),  128'(1'b1));
    chk("mrl_dec_reset", 128'(dec_reset), 128'(1'b1));
    chk("mrl_dec_in",    dec_in,          128'd0);
    chk("mrl_out_valid", 128'(out_valid), 128'(1'b0));
    chk("mrl_busy",      128'(busy),      128'(1'b0));
    #1 rstN = 1'b1;
    tick();

    // Reset mid-RUN
    send_block(ct_r);
    repeat (4) tick();
    chk("mrr_busy_before", 128'(busy), 128'(1'b1));
    #2 rstN = 1'b0;
    #1;
    chk("mrr_dec_reset", 128'(dec_reset), 128'(1'b1));
    chk("mrr_in_ready",  128'(in_ready),  128'(1'b1));
    chk("mrr_dec_in",    dec_in,          128'd0);
    chk("mrr_busy",      128'(busy),      128'(1'b0));
    #1 rstN = 1'b1;
    tick();

    // Fresh block after reset
    send_block(FIPS_CT);
    chk("fresh_dec_in", dec_in, FIPS_CT);
    wait_out(0, "lat_fresh");
    drain(FIPS_PT, "fresh");

    // Back-to-back blocks
    send_block(ct_a);
    wait_out(0, "lat_a");
`ifdef DEC_LOADER_OVERLAP_EN
    chk("b2b_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("a_byte%0d", j), 128'(out_byte), 128'(get_byte(pt_a, j)));
      in_valid = 1'b1;
      in_byte  = get_byte(ct_b, j);
      tick();
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
    chk("b2b_valid_low", 128'(out_valid), 128'(1'b0));
    chk("b2b_busy",      128'(busy),      128'(1'b1));
    chk("b2b_dec_reset", 128'(dec_reset), 128'(1'b0));
    chk("b2b_dec_in",    dec_in,          ct_b);
    wait_out(0, "lat_b");
`else
    chk("b2b_in_ready", 128'(in_ready), 128'(1'b0));
    drain(pt_a, "a");
    chk("b2b_ready_after", 128'(in_ready), 128'(1'b1));
    send_block(ct_b);
    chk("b2b_dec_in", dec_in, ct_b);
    wait_out(0, "lat_b");
`endif
    drain(pt_b, "b");
    chk("end_busy", 128'(busy), 128'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
